// File: rtl/shift_rate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shift_rate_ctrl                                              |
// | Description : Sequencer for the LEDR/HEX shift datapath. Debounces the     |
// |               speed keys, holds a saturating speed level, emits a 1-cycle  |
// |               shift strobe at the selected rate and registers the shifter  |
// |               direction / fill selects. Drives the LEDG speed bar.         |
// | Options     : HOLD_REPEAT_EN - auto-repeat press pulses while a key is held|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module shift_rate_ctrl #(
  parameter int BASE_DIV   = 50_000_000,
  parameter int DB_CYC     = 500_000,
  parameter int MIN_SPEED  = 1,
  parameter int MAX_SPEED  = 8,
  parameter int REPEAT_CYC = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  input  logic [1:0] sw_dir,
  input  logic [1:0] sw_fill,
  output logic       shift_en,
  output logic [1:0] shift_dir,
  output logic [1:0] fill_sel,
  output logic [3:0] speed,
  output logic [7:0] ledg
);

  localparam int CNT_W = $clog2(BASE_DIV + 1);
  localparam int DB_W  = $clog2(DB_CYC + 1);
`ifdef HOLD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYC + 1);
`else
  // Repeat interval is only meaningful when auto-repeat is built in.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_CYC > 0);
`endif

  localparam logic [1:0] DIR_HOLD   = 2'b00;
  localparam logic [1:0] DIR_RIGHT  = 2'b01;
  localparam logic [1:0] DIR_LEFT   = 2'b10;
  localparam logic [1:0] FILL_WRAP  = 2'b00;
  localparam logic [1:0] FILL_ONES  = 2'b01;
  localparam logic [1:0] FILL_ZEROS = 2'b10;

  typedef enum logic [1:0] {
    REL        = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_t;

  // Reload value of the tick counter for a speed level: max(1, BASE_DIV >> (lvl-1)) - 1.
  function automatic logic [CNT_W-1:0] period_m1(input logic [3:0] lvl);
    int p;
    p = BASE_DIV >> (lvl - 4'd1);
    if (p < 1) p = 1;
    return CNT_W'(p - 1);
  endfunction

  // Thermometer bar: bit i lit iff i < lvl.
  function automatic logic [7:0] thermo(input logic [3:0] lvl);
    logic [7:0] bar;
    for (int i = 0; i < 8; i++) bar[i] = (lvl > 4'(i));
    return bar;
  endfunction

  logic [1:0] up_sync, dn_sync;
  logic [1:0] dir_s1, dir_s2, fill_s1, fill_s2;
  logic [1:0] key_in;
  logic [1:0] press;

  // Two-flop synchronisers for every raw input; keys idle high, switches idle low.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      up_sync <= 2'b11;
      dn_sync <= 2'b11;
      dir_s1  <= 2'b00;
      dir_s2  <= 2'b00;
      fill_s1 <= 2'b00;
      fill_s2 <= 2'b00;
    end else begin
      up_sync <= {up_sync[0], key_up_n};
      dn_sync <= {dn_sync[0], key_dn_n};
      dir_s1  <= sw_dir;
      dir_s2  <= dir_s1;
      fill_s1 <= sw_fill;
      fill_s2 <= fill_s1;
    end
  end

  assign key_in = {dn_sync[1], up_sync[1]};

  // One debouncer per key: index 0 = up, index 1 = down.
  for (genvar k = 0; k < 2; k++) begin : g_key
    db_state_t       st, st_nxt;
    logic [DB_W-1:0] cnt, cnt_nxt;
    logic            pulse, pulse_nxt;
`ifdef HOLD_REPEAT_EN
    logic [REP_W-1:0] rep, rep_nxt;
`endif

    // Debounce state register; the press pulse is registered so it is glitch-free.
    always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
        st    <= REL;
        cnt   <= '0;
        pulse <= 1'b0;
`ifdef HOLD_REPEAT_EN
        rep   <= '0;
`endif
      end else begin
        st    <= st_nxt;
        cnt   <= cnt_nxt;
        pulse <= pulse_nxt;
`ifdef HOLD_REPEAT_EN
        rep   <= rep_nxt;
`endif
      end
    end

    // Debounce next-state: DB_CYC stable cycles needed to accept either edge.
    always_comb begin
      st_nxt    = st;
      cnt_nxt   = cnt;
      pulse_nxt = 1'b0;
      case (st)
        REL: begin
          if (!key_in[k]) begin
            st_nxt  = PRESS_WAIT;
            cnt_nxt = '0;
          end
        end
        PRESS_WAIT: begin
          if (key_in[k]) begin
            st_nxt = REL;
          end else if (cnt == DB_W'(DB_CYC - 1)) begin
            st_nxt    = HELD;
            pulse_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + DB_W'(1);
          end
        end
        HELD: begin
          if (key_in[k]) begin
            st_nxt  = REL_WAIT;
            cnt_nxt = '0;
          end
        end
        REL_WAIT: begin
          if (!key_in[k]) begin
            st_nxt = HELD;
          end else if (cnt == DB_W'(DB_CYC - 1)) begin
            st_nxt = REL;
          end else begin
            cnt_nxt = cnt + DB_W'(1);
          end
        end
        default: st_nxt = REL;
      endcase
`ifdef HOLD_REPEAT_EN
      // Repeat counter only runs while staying in HELD; any exit clears it.
      rep_nxt = '0;
      if (st == HELD && st_nxt == HELD) begin
        if (rep == REP_W'(REPEAT_CYC - 1)) begin
          pulse_nxt = 1'b1;
        end else begin
          rep_nxt = rep + REP_W'(1);
        end
      end
`endif
    end

    assign press[k] = pulse;
  end

  logic [3:0] speed_nxt;

  // Speed step: a lone up or down pulse moves one level, saturating at the ends.
  always_comb begin
    speed_nxt = speed;
    if (press[0] && !press[1] && speed < 4'(MAX_SPEED)) begin
      speed_nxt = speed + 4'd1;
    end else if (press[1] && !press[0] && speed > 4'(MIN_SPEED)) begin
      speed_nxt = speed - 4'd1;
    end
  end

  // Speed level and its bar update together.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      speed <= 4'(MIN_SPEED);
      ledg  <= thermo(4'(MIN_SPEED));
    end else begin
      speed <= speed_nxt;
      ledg  <= thermo(speed_nxt);
    end
  end

  logic [1:0] dir_req, fill_req;

  // Decode the synchronised switches into requested selects (right wins over left).
  always_comb begin
    dir_req = DIR_HOLD;
    if (dir_s2[0])      dir_req = DIR_RIGHT;
    else if (dir_s2[1]) dir_req = DIR_LEFT;
    fill_req = FILL_WRAP;
    if (fill_s2 == 2'b01)      fill_req = FILL_ONES;
    else if (fill_s2 == 2'b10) fill_req = FILL_ZEROS;
  end

  logic [CNT_W-1:0] tick_cnt, tick_cnt_nxt;
  logic             strobe_nxt;
  logic             sel_defer, defer_nxt, sel_change;
  logic [1:0]       dir_nxt, fill_nxt;

  // Rate counter, strobe and select hand-off. Selects never change on the edge
  // that raises the strobe. At period 1 the strobe would block them forever, so
  // a deferred change takes the next edge and that one strobe is skipped.
  always_comb begin
    tick_cnt_nxt = tick_cnt;
    strobe_nxt   = 1'b0;
    if (speed_nxt != speed || shift_dir == DIR_HOLD) begin
      tick_cnt_nxt = period_m1(speed_nxt);
    end else if (tick_cnt == '0) begin
      tick_cnt_nxt = period_m1(speed);
      strobe_nxt   = !sel_defer;
    end else begin
      tick_cnt_nxt = tick_cnt - CNT_W'(1);
    end
    sel_change = (dir_req != shift_dir) || (fill_req != fill_sel);
    dir_nxt    = strobe_nxt ? shift_dir : dir_req;
    fill_nxt   = strobe_nxt ? fill_sel  : fill_req;
    defer_nxt  = strobe_nxt && sel_change;
  end

  // Rate counter / strobe / select registers.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      tick_cnt  <= CNT_W'(BASE_DIV - 1);
      shift_en  <= 1'b0;
      shift_dir <= DIR_HOLD;
      fill_sel  <= FILL_WRAP;
      sel_defer <= 1'b0;
    end else begin
      tick_cnt  <= tick_cnt_nxt;
      shift_en  <= strobe_nxt;
      shift_dir <= dir_nxt;
      fill_sel  <= fill_nxt;
      sel_defer <= defer_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_rate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_shift_rate_ctrl                                           |
// | Description : Self-checking bench for shift_rate_ctrl with randomised key  |
// |               and switch stimulus against a behavioural reference model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_shift_rate_ctrl;

  localparam int BASE_DIV   = 128;
  localparam int DB_CYC     = 4;
  localparam int REPEAT_CYC = 32;
  localparam int MIN_SPEED  = 1;
  localparam int MAX_SPEED  = 8;

  logic       clk = 1'b0;
  logic       key0 = 1'b0;
  logic       key_up_n = 1'b1;
  logic       key_dn_n = 1'b1;
  logic [1:0] sw_dir = 2'b00;
  logic [1:0] sw_fill = 2'b00;
  logic       shift_en;
  logic [1:0] shift_dir;
  logic [1:0] fill_sel;
  logic [3:0] speed;
  logic [7:0] ledg;

  int n_checks = 0;
  int n_errors = 0;
  int m_speed  = 1;

  always #5 clk = ~clk;

  shift_rate_ctrl #(
    .BASE_DIV  (BASE_DIV),
    .DB_CYC    (DB_CYC),
    .MIN_SPEED (MIN_SPEED),
    .MAX_SPEED (MAX_SPEED),
    .REPEAT_CYC(REPEAT_CYC)
  ) dut (
    .CLOCK_50 (clk),
    .KEY0     (key0),
    .key_up_n (key_up_n),
    .key_dn_n (key_dn_n),
    .sw_dir   (sw_dir),
    .sw_fill  (sw_fill),
    .shift_en (shift_en),
    .shift_dir(shift_dir),
    .fill_sel (fill_sel),
    .speed    (speed),
    .ledg     (ledg)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_period(input int s);
    int p;
    p = BASE_DIV / (1 << (s - 1));
    return (p < 1) ? 1 : p;
  endfunction

  function automatic int model_dir(input logic [1:0] sw);
    if (sw[0]) return 1;
    if (sw[1]) return 2;
    return 0;
  endfunction

  function automatic int model_fill(input logic [1:0] sw);
    if (sw == 2'b01) return 1;
    if (sw == 2'b10) return 2;
    return 0;
  endfunction

  function automatic int model_bar(input int s);
    return (1 << s) - 1;
  endfunction

  // A press is accepted when the key stays low for at least the debounce time.
  function automatic void model_press(input bit up, input bit dn, input int len);
    if (len < DB_CYC) return;
    if (up && !dn && m_speed < MAX_SPEED) m_speed++;
    else if (dn && !up && m_speed > MIN_SPEED) m_speed--;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!shift_en && n < 400);
    if (!shift_en) begin
      check("strobe_timeout", 0, 1);
      n = -1;
    end
  endtask

  task automatic wait_dir(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (shift_dir == 2'b00 && n < 20);
    if (shift_dir == 2'b00) begin
      check("dir_timeout", 0, 1);
      n = -1;
    end
  endtask

  task automatic press(input bit up, input bit dn, input int len);
    key_up_n = !up;
    key_dn_n = !dn;
    tick(len);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    tick(12);
    model_press(up, dn, len);
    check("speed", int'(speed), m_speed);
    check("ledg", int'(ledg), model_bar(m_speed));
  endtask

  task automatic measure_period;
    int n;
    wait_strobe(n);
    wait_strobe(n);
    check("period", n, model_period(m_speed));
  endtask

  logic [1:0] tdir [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
  logic [1:0] tfill[4] = '{2'b11, 2'b10, 2'b01, 2'b00};

  initial begin
    int n;
    int cnt;
    int kind;
    int len;
    bit up, dn;

    // Reset state
    tick(2);
    check("rst_speed", int'(speed), 1);
    check("rst_ledg", int'(ledg), 8'h01);
    check("rst_shift_en", int'(shift_en), 0);
    check("rst_shift_dir", int'(shift_dir), 0);
    check("rst_fill_sel", int'(fill_sel), 0);

    // Right shift at speed 1
    key0   = 1'b1;
    sw_dir = 2'b01;
    wait_dir(n);
    check("dir_latency", n, 3);
    check("dir_right", int'(shift_dir), 1);
    check("fill_wrap", int'(fill_sel), 0);
    wait_strobe(n);
    check("first_strobe", n, model_period(1));
    measure_period();

    // Select decoding: fixed corner patterns then random ones
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        sw_dir  = tdir[i];
        sw_fill = tfill[i];
      end else begin
        sw_dir  = 2'($urandom_range(0, 3));
        sw_fill = 2'($urandom_range(0, 3));
      end
      tick(5);
      check("sel_dir", int'(shift_dir), model_dir(sw_dir));
      check("sel_fill", int'(fill_sel), model_fill(sw_fill));
    end

    // Direction hold: no strobes at all
    sw_dir = 2'b00;
    tick(5);
    cnt = 0;
    repeat (300) begin
      tick(1);
      if (shift_en) cnt++;
    end
    check("hold_no_strobe", cnt, 0);

    // Switch change landing on a strobe cycle is applied one cycle later
    sw_dir  = 2'b01;
    sw_fill = 2'b00;
    tick(6);
    wait_strobe(n);
    tick(model_period(1) - 3);
    sw_fill = 2'b10;
    tick(3);
    check("coincide_strobe", int'(shift_en), 1);
    check("coincide_fill_old", int'(fill_sel), 0);
    tick(1);
    check("coincide_fill_new", int'(fill_sel), 2);
    check("coincide_no_strobe", int'(shift_en), 0);
    sw_fill = 2'b00;
    tick(5);

    // Deterministic key cases
    press(1'b0, 1'b1, 10);   // down at minimum
    press(1'b1, 1'b0, 10);   // up to 2
    measure_period();
    press(1'b1, 1'b0, 3);    // glitch
    press(1'b1, 1'b1, 10);   // both together
    for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 10);
    check("sat_speed", int'(speed), 8);
    measure_period();
    cnt = 0;
    repeat (6) begin
      tick(1);
      if (shift_en) cnt++;
    end
    check("max_held_high", cnt, 6);

    // Randomised key sequence
    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(0, 9));
      up   = (kind <= 4) || (kind >= 8);
      dn   = (kind == 5) || (kind == 6) || (kind >= 8);
      if (kind == 7) begin
        up = $urandom_range(0, 1) == 1;
        dn = !up;
      end
      len = (kind == 7 || kind == 9) ? int'($urandom_range(1, DB_CYC - 1))
                                     : int'($urandom_range(DB_CYC + 2, 12));
      press(up, dn, len);
      if (i % 6 == 5) measure_period();
    end

    // Move to speed 5, then reset just before a strobe
    for (int i = 0; i < 16 && m_speed != 5; i++) begin
      if (m_speed < 5) press(1'b1, 1'b0, 8);
      else press(1'b0, 1'b1, 8);
    end
    check("pre_reset_speed", int'(speed), 5);
    wait_strobe(n);
    tick(model_period(5) - 1);
    key0 = 1'b0;
    tick(1);
    key0 = 1'b1;
    m_speed = 1;
    check("midrst_speed", int'(speed), 1);
    check("midrst_ledg", int'(ledg), 8'h01);
    check("midrst_shift_en", int'(shift_en), 0);
    check("midrst_shift_dir", int'(shift_dir), 0);
    wait_dir(n);
    check("midrst_dir_latency", n, 3);
    wait_strobe(n);
    check("midrst_first_strobe", n, model_period(1));

    // Long hold from speed 1
    key0 = 1'b0;
    tick(1);
    key0 = 1'b1;
    tick(4);
    key_up_n = 1'b0;
    tick(90);
    key_up_n = 1'b1;
    tick(15);
`ifdef HOLD_REPEAT_EN
    check("long_hold_speed", int'(speed), 4);
`else
    check("long_hold_speed", int'(speed), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
